send_scheduler: RTL and testbench

SEND_SCHEDULER -- requirements
Module: send_scheduler

---
 rtl/send_sched_pkg.sv | 12 +
 rtl/send_scheduler_if.sv | 25 ++
 rtl/send_sched_channel.sv | 99 +++++++++
 rtl/send_scheduler.sv | 65 ++++++
 tb/tb_send_scheduler.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/send_sched_pkg.sv
// Shared types and default constants for the send scheduler.
// The optional statistics counters are built only when SEND_SCHED_STATS_EN is defined.
package send_sched_pkg;
  typedef enum logic {IDLE, PULSE} ch_state_t;

  localparam int STAT_W        = 16;
  localparam int TMR_W         = 4;
  localparam int DEF_NUM_CH    = 2;
  localparam int DEF_CNT_W     = 32;
  localparam int DEF_ADDR_W    = 25;
  localparam int DEF_PULSE_LEN = 3;
endpackage

// File: rtl/send_scheduler_if.sv
// Configuration, busy and command bus between the scheduler and its host and senders.
interface send_scheduler_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 25
) ();
  logic                     enable;
  logic [CNT_W-1:0]         cfg_period;
  logic [NUM_CH*CNT_W-1:0]  cfg_offset;
  logic [NUM_CH*ADDR_W-1:0] cfg_addr;
  logic [NUM_CH-1:0]        ch_busy;
  logic [NUM_CH-1:0]        cmd_send;
  logic [NUM_CH*ADDR_W-1:0] start_ram_addr;
  logic [NUM_CH*16-1:0]     sent_cnt;
  logic [NUM_CH*16-1:0]     skip_cnt;

  modport master (
    output enable, cfg_period, cfg_offset, cfg_addr, ch_busy,
    input  cmd_send, start_ram_addr, sent_cnt, skip_cnt
  );
  modport slave (
    input  enable, cfg_period, cfg_offset, cfg_addr, ch_busy,
    output cmd_send, start_ram_addr, sent_cnt, skip_cnt
  );
endinterface

// File: rtl/send_sched_channel.sv
// One send channel: slot match, fixed-length command pulse, address latch and
// optional sent/skip statistics (SEND_SCHED_STATS_EN).
module send_sched_channel
  import send_sched_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int ADDR_W    = 25,
  parameter int PULSE_LEN = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              frame_vld,
  input  logic [CNT_W-1:0]  cnt,
  input  logic [CNT_W-1:0]  period,
  input  logic [CNT_W-1:0]  offset,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic              busy,
  output logic              cmd_send,
  output logic [ADDR_W-1:0] start_addr,
  output logic [STAT_W-1:0] sent_cnt,
  output logic [STAT_W-1:0] skip_cnt
);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(PULSE_LEN - 1);

  ch_state_t         state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              slot, fire;

  // Offsets outside the frame can never match, even if the counter briefly
  // sits above a freshly shortened period.
  assign slot = enable && frame_vld && (cnt == offset) && (offset < period) &&
                (state_q == IDLE);
  assign fire = slot && !busy;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: if (fire) begin
        state_d = PULSE;
        tmr_d   = TMR_LAST;
        addr_d  = cfg_addr;
      end
      PULSE: begin
        if (tmr_q == '0) state_d = IDLE;
        else             tmr_d   = tmr_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      addr_q  <= addr_d;
    end
  end

  assign cmd_send   = (state_q == PULSE);
  assign start_addr = addr_q;

`ifdef SEND_SCHED_STATS_EN
  logic              skip;
  logic [STAT_W-1:0] sent_q, sent_d, skip_q, skip_d;

  assign skip = slot && busy;

  always_comb begin
    sent_d = sent_q;
    skip_d = skip_q;
    if (fire && (sent_q != '1)) sent_d = sent_q + 1'b1;
    if (skip && (skip_q != '1)) skip_d = skip_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sent_q <= '0;
      skip_q <= '0;
    end else begin
      sent_q <= sent_d;
      skip_q <= skip_d;
    end
  end

  assign sent_cnt = sent_q;
  assign skip_cnt = skip_q;
`else
  assign sent_cnt = '0;
  assign skip_cnt = '0;
`endif
endmodule

// File: rtl/send_scheduler.sv
// Frame-slot packet-send scheduler: one shared frame counter drives NUM_CH
// independent channels. Optional statistics: SEND_SCHED_STATS_EN.
module send_scheduler
  import send_sched_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int PULSE_LEN = DEF_PULSE_LEN
) (
  input logic              clk,
  input logic              rst_n,
  send_scheduler_if.slave  bus
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frame_vld;

  logic [NUM_CH-1:0]             cmd_w;
  logic [NUM_CH-1:0][ADDR_W-1:0] addr_w;
  logic [NUM_CH-1:0][STAT_W-1:0] sent_w, skip_w;

  // A frame shorter than one pulse cannot host a slot, so the counter parks at 0.
  assign frame_vld = bus.cfg_period > CNT_W'(PULSE_LEN);

  always_comb begin
    cnt_d = cnt_q;
    if (!frame_vld)                               cnt_d = '0;
    else if (bus.enable) begin
      if (cnt_q >= bus.cfg_period - 1'b1)         cnt_d = '0;
      else                                        cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    send_sched_channel #(
      .CNT_W    (CNT_W),
      .ADDR_W   (ADDR_W),
      .PULSE_LEN(PULSE_LEN)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (bus.enable),
      .frame_vld (frame_vld),
      .cnt       (cnt_q),
      .period    (bus.cfg_period),
      .offset    (bus.cfg_offset[i*CNT_W +: CNT_W]),
      .cfg_addr  (bus.cfg_addr[i*ADDR_W +: ADDR_W]),
      .busy      (bus.ch_busy[i]),
      .cmd_send  (cmd_w[i]),
      .start_addr(addr_w[i]),
      .sent_cnt  (sent_w[i]),
      .skip_cnt  (skip_w[i])
    );
  end

  assign bus.cmd_send       = cmd_w;
  assign bus.start_ram_addr = addr_w;
  assign bus.sent_cnt       = sent_w;
  assign bus.skip_cnt       = skip_w;
endmodule

// File: tb/tb_send_scheduler.sv
// Directed bench for send_scheduler (NUM_CH=2, PULSE_LEN=3), hand-computed
// expectations; statistics expectations follow SEND_SCHED_STATS_EN.
module tb_send_scheduler;
`ifdef SEND_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  send_scheduler_if #(.NUM_CH(2), .CNT_W(32), .ADDR_W(25)) bus_if ();

  send_scheduler #(.NUM_CH(2), .CNT_W(32), .ADDR_W(25), .PULSE_LEN(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cnt(input logic [31:0] v);
    int k = 0;
    while (dut.cnt_q !== v && k < 3000) begin
      tick();
      k++;
    end
    if (k >= 3000) chk("wait_cnt_timeout", {32'd0, dut.cnt_q}, {32'd0, v});
  endtask

  function automatic logic [15:0] sent(input int i);
    logic [31:0] v;
    v = bus_if.sent_cnt;
    return v[i*16 +: 16];
  endfunction

  function automatic logic [15:0] skip(input int i);
    logic [31:0] v;
    v = bus_if.skip_cnt;
    return v[i*16 +: 16];
  endfunction

  function automatic logic [24:0] addr(input int i);
    logic [49:0] v;
    v = bus_if.start_ram_addr;
    return v[i*25 +: 25];
  endfunction

  initial begin
    rst_n             = 1'b0;
    bus_if.enable     = 1'b0;
    bus_if.cfg_period = 32'd512;
    bus_if.cfg_offset = {32'd511, 32'd255};
    bus_if.cfg_addr   = {25'h1000, 25'd1};
    bus_if.ch_busy    = 2'b00;
    #12;
    chk("rst_cmd",  bus_if.cmd_send, 2'b00);
    chk("rst_cnt",  dut.cnt_q, 32'd0);
    chk("rst_addr", bus_if.start_ram_addr, 50'd0);
    chk("rst_sent", bus_if.sent_cnt, 32'd0);
    tick();
    rst_n         = 1'b1;
    bus_if.enable = 1'b1;

    // ch0 slot 255 -> pulse at 256..258; ch1 slot 511 -> pulse at 0..2
    wait_cnt(32'd255);
    tick();
    chk("ch0_rise", bus_if.cmd_send, 2'b01);
    chk("ch0_cnt",  dut.cnt_q, 32'd256);
    chk("ch0_addr", addr(0), 25'd1);
    tick(); tick();
    chk("ch0_hold3", bus_if.cmd_send, 2'b01);
    tick();
    chk("ch0_fall", bus_if.cmd_send, 2'b00);
    wait_cnt(32'd511);
    tick();
    chk("ch1_wrap_cnt", dut.cnt_q, 32'd0);
    chk("ch1_rise", bus_if.cmd_send, 2'b10);
    chk("ch1_addr", addr(1), 25'h1000);
    chk("ch0_addr_hold", addr(0), 25'd1);
    tick(); tick(); tick();
    chk("ch1_fall", bus_if.cmd_send, 2'b00);
    chk("sent0_a", sent(0), STATS ? 16'd1 : 16'd0);
    chk("sent1_a", sent(1), STATS ? 16'd1 : 16'd0);

    // equal offsets fire together
    bus_if.cfg_offset = {32'd100, 32'd100};
    wait_cnt(32'd100);
    tick();
    chk("eq_rise", bus_if.cmd_send, 2'b11);
    chk("eq_addr0", addr(0), 25'd1);
    chk("eq_addr1", addr(1), 25'h1000);
    tick(); tick(); tick();

    // busy ch0 at its slot -> skip, ch1 fires
    bus_if.ch_busy = 2'b01;
    wait_cnt(32'd100);
    tick();
    chk("busy_cmd", bus_if.cmd_send, 2'b10);
    tick(); tick(); tick();
    bus_if.ch_busy = 2'b00;
    chk("busy_skip0", skip(0), STATS ? 16'd1 : 16'd0);
    chk("busy_sent0", sent(0), STATS ? 16'd2 : 16'd0);
    chk("busy_sent1", sent(1), STATS ? 16'd3 : 16'd0);

    // enable dropped at counter 300 with ch0 pulse in flight; ch1 out of frame
    bus_if.cfg_offset = {32'd600, 32'd298};
    wait_cnt(32'd298);
    tick();
    chk("en_rise", bus_if.cmd_send, 2'b01);
    tick();
    chk("en_cnt300", dut.cnt_q, 32'd300);
    bus_if.enable = 1'b0;
    tick();
    chk("en_pulse3", bus_if.cmd_send, 2'b01);
    chk("en_hold_cnt", dut.cnt_q, 32'd300);
    for (int i = 0; i < 49; i++) tick();
    chk("en_off_cmd", bus_if.cmd_send, 2'b00);
    chk("en_off_cnt", dut.cnt_q, 32'd300);
    bus_if.enable = 1'b1;
    tick();
    chk("en_resume", dut.cnt_q, 32'd301);

    // period too short: counter parked, nothing fires
    bus_if.cfg_period = 32'd3;
    bus_if.cfg_offset = {32'd600, 32'd0};
    tick();
    chk("inv_cnt0", dut.cnt_q, 32'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("inv_cmd", bus_if.cmd_send, 2'b00);
    chk("inv_cnt_hold", dut.cnt_q, 32'd0);
    bus_if.cfg_period = 32'd600;
    bus_if.cfg_offset = {32'd600, 32'd10};
    wait_cnt(32'd10);
    tick();
    chk("p600_rise", bus_if.cmd_send, 2'b01);
    chk("sent0_b", sent(0), STATS ? 16'd4 : 16'd0);
    chk("skip1_b", skip(1), 16'd0);
    chk("sent1_b", sent(1), STATS ? 16'd3 : 16'd0);
    tick();

    // reset mid-pulse
    rst_n = 1'b0;
    #1;
    chk("mrst_cmd",  bus_if.cmd_send, 2'b00);
    chk("mrst_cnt",  dut.cnt_q, 32'd0);
    chk("mrst_addr", addr(0), 25'd0);
    chk("mrst_sent", bus_if.sent_cnt, 32'd0);
    chk("mrst_skip", bus_if.skip_cnt, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_cmd", bus_if.cmd_send, 2'b00);
    chk("post_rst_cnt", dut.cnt_q, 32'd1);
    wait_cnt(32'd10);
    chk("pre_match_cmd", bus_if.cmd_send, 2'b00);
    tick();
    chk("fresh_rise", bus_if.cmd_send, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
